// File: rtl/ras_stack.sv
// Circular return-address stack with one-cycle overflow/underflow pulses.
// Define RAS_CKPT_EN to add checkpoint save/restore of {ptr,count}.
module ras_stack #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned VLEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
`ifdef RAS_CKPT_EN
  input  logic                       ckpt_save_i,
  input  logic                       ckpt_restore_i,
`endif
  input  logic [VLEN-1:0]            data_i,
  output logic [VLEN-1:0]            data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH-1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [VLEN-1:0]  addr_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    ptr_q, ptr_d, ptr_inc, ptr_dec, wr_idx;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_en;
`ifdef RAS_CKPT_EN
  logic [PW-1:0]    ckpt_ptr_q, ckpt_ptr_d;
  logic [CW-1:0]    ckpt_cnt_q, ckpt_cnt_d;
`endif

  // Explicit wrap so non-power-of-two depths never index past the buffer
  assign ptr_inc = (ptr_q == PTR_MAX) ? '0 : ptr_q + PW'(1);
  assign ptr_dec = (ptr_q == '0) ? PTR_MAX : ptr_q - PW'(1);

  assign data_o      = addr_q[ptr_q];
  assign valid_o     = valid_q[ptr_q];
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

  always_comb begin
    valid_d     = valid_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = ptr_q;
`ifdef RAS_CKPT_EN
    ckpt_ptr_d  = ckpt_ptr_q;
    ckpt_cnt_d  = ckpt_cnt_q;
`endif
    if (flush_i) begin
      valid_d = '0;
      ptr_d   = '0;
      count_d = '0;
    end
`ifdef RAS_CKPT_EN
    else if (ckpt_restore_i) begin
      ptr_d   = ckpt_ptr_q;
      count_d = ckpt_cnt_q;
    end
`endif
    else begin
`ifdef RAS_CKPT_EN
      if (ckpt_save_i) begin
        ckpt_ptr_d = ptr_q;
        ckpt_cnt_d = count_q;
      end
`endif
      if (push_i && pop_i && (count_q != '0)) begin
        // Call-and-return in one cycle: replace the top in place
        wr_en           = 1'b1;
        wr_idx          = ptr_q;
        valid_d[ptr_q]  = 1'b1;
      end else if (push_i) begin
        wr_en            = 1'b1;
        wr_idx           = ptr_inc;
        ptr_d            = ptr_inc;
        valid_d[ptr_inc] = 1'b1;
        if (count_q == CNT_MAX) begin
          overflow_d = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end else if (pop_i) begin
        if (count_q == '0) begin
          underflow_d = 1'b1;
        end else begin
          valid_d[ptr_q] = 1'b0;
          ptr_d          = ptr_dec;
          count_d        = count_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q     <= '0;
      ptr_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifdef RAS_CKPT_EN
      ckpt_ptr_q  <= '0;
      ckpt_cnt_q  <= '0;
`endif
    end else begin
      valid_q     <= valid_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifdef RAS_CKPT_EN
      ckpt_ptr_q  <= ckpt_ptr_d;
      ckpt_cnt_q  <= ckpt_cnt_d;
`endif
    end
  end

  // Address storage carries no reset; valid bits qualify it
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_en) begin
      addr_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: tb/tb_ras_stack.sv
// Scoreboard bench for ras_stack: DEPTH=2 and DEPTH=3 instances share stimulus,
// each checked against a queue-based stack model.
module tb_ras_stack;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, flush = 1'b0, push = 1'b0, pop = 1'b0;
  logic [31:0] din = '0;
  logic        save = 1'b0, restore = 1'b0;

  logic [31:0] dat_o [2];
  logic        vld_o [2];
  logic [1:0]  cnt_o [2];
  logic        ovf_o [2];
  logic        unf_o [2];

  ras_stack #(.DEPTH(2), .VLEN(32)) u_d2 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .pop_i(pop),
`ifdef RAS_CKPT_EN
    .ckpt_save_i(save), .ckpt_restore_i(restore),
`endif
    .data_i(din), .data_o(dat_o[0]), .valid_o(vld_o[0]), .count_o(cnt_o[0]),
    .overflow_o(ovf_o[0]), .underflow_o(unf_o[0])
  );

  ras_stack #(.DEPTH(3), .VLEN(32)) u_d3 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .push_i(push), .pop_i(pop),
`ifdef RAS_CKPT_EN
    .ckpt_save_i(save), .ckpt_restore_i(restore),
`endif
    .data_i(din), .data_o(dat_o[1]), .valid_o(vld_o[1]), .count_o(cnt_o[1]),
    .overflow_o(ovf_o[1]), .underflow_o(unf_o[1])
  );

  typedef struct {
    int          cnt;
    bit          vld;
    bit          chkv;
    logic [31:0] dat;
    bit          ovf;
    bit          unf;
  } exp_t;

  exp_t        exp_q [2][$];
  logic [31:0] stk   [2][$];
  logic [31:0] snap  [2][$];
  bit          vld_unk [2];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s DEPTH=%0d got=%0h exp=%0h t=%0t", name, i + 2, act, exp, $time);
    end
  endtask

  // Reference: a plain LIFO of addresses, oldest at the front
  task automatic model(input int i, input bit r, input bit f, input bit pu, input bit po,
                       input logic [31:0] d, input bit sv, input bit rs);
    int   dp;
    exp_t e;
    dp = i + 2;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (!r) begin
      stk[i].delete();
      snap[i].delete();
      vld_unk[i] = 1'b0;
    end else if (f) begin
      stk[i].delete();
      vld_unk[i] = 1'b0;
`ifdef RAS_CKPT_EN
    end else if (rs) begin
      stk[i] = snap[i];
      vld_unk[i] = 1'b1;
`endif
    end else begin
`ifdef RAS_CKPT_EN
      if (sv) snap[i] = stk[i];
`endif
      if (pu && po && stk[i].size() > 0) begin
        stk[i][stk[i].size() - 1] = d;
      end else if (pu) begin
        if (stk[i].size() == dp) begin
          void'(stk[i].pop_front());
          e.ovf = 1'b1;
        end
        stk[i].push_back(d);
      end else if (po) begin
        if (stk[i].size() == 0) e.unf = 1'b1;
        else void'(stk[i].pop_back());
      end
    end
    e.cnt  = stk[i].size();
    e.vld  = (e.cnt > 0);
    e.dat  = e.vld ? stk[i][e.cnt - 1] : '0;
    e.chkv = !vld_unk[i];
    exp_q[i].push_back(e);
  endtask

  task automatic step(input bit r, input bit f, input bit pu, input bit po,
                      input logic [31:0] d, input bit sv = 1'b0, input bit rs = 1'b0);
    @(negedge clk);
    rst_n = r; flush = f; push = pu; pop = po; din = d; save = sv; restore = rs;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) model(i, r, f, pu, po, d, sv, rs);
  endtask

  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (exp_q[i].size() > 0) begin
          me = exp_q[i].pop_front();
          chk("count", i, 32'(cnt_o[i]), 32'(me.cnt));
          chk("overflow", i, 32'(ovf_o[i]), 32'(me.ovf));
          chk("underflow", i, 32'(unf_o[i]), 32'(me.unf));
          if (me.chkv) chk("valid", i, 32'(vld_o[i]), 32'(me.vld));
          if (me.vld) chk("data", i, dat_o[i], me.dat);
        end
      end
    end
  end

  initial begin
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    // basic push/pop
    step(1, 0, 1, 0, 32'h100);
    step(1, 0, 1, 0, 32'h200);
    step(1, 0, 0, 1, '0);
    // fill, overflow, drain, underflow
    step(1, 1, 0, 0, '0);
    step(1, 0, 1, 0, 32'h100);
    step(1, 0, 1, 0, 32'h200);
    step(1, 0, 1, 0, 32'h300);
    step(1, 0, 0, 0, '0);
    for (int k = 0; k < 4; k++) step(1, 0, 0, 1, '0);
    step(1, 0, 0, 0, '0);
    // simultaneous push+pop, non-empty and empty
    step(1, 0, 1, 0, 32'h400);
    step(1, 0, 1, 1, 32'h500);
    step(1, 1, 0, 0, '0);
    step(1, 0, 1, 1, 32'h600);
    // wrap with seven pushes, then flush racing a push
    step(1, 1, 0, 0, '0);
    for (int k = 1; k <= 7; k++) step(1, 0, 1, 0, 32'(k));
    step(1, 1, 1, 0, 32'h77);
    step(1, 0, 0, 0, '0);
    // reset mid-operation while pushing into a full stack
    step(1, 0, 1, 0, 32'hA1);
    step(1, 0, 1, 0, 32'hA2);
    step(0, 0, 1, 0, 32'hA3);
    step(1, 0, 0, 0, '0);
`ifdef RAS_CKPT_EN
    step(1, 1, 0, 0, '0);
    step(1, 0, 1, 0, 32'hA0);
    step(1, 0, 0, 0, '0, 1'b1, 1'b0);
    step(1, 0, 1, 0, 32'hB0);
    step(1, 0, 0, 1, '0);
    step(1, 0, 0, 1, '0);
    step(1, 0, 0, 0, '0, 1'b0, 1'b1);
    step(1, 0, 1, 0, 32'hC0, 1'b0, 1'b1);
    step(1, 1, 0, 0, '0);
`endif
    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      int r;
      r = $urandom_range(0, 99);
      step((r < 2) ? 1'b0 : 1'b1, (r >= 2 && r < 6) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (exp_q[i].size() != 0) begin
        n_fail++;
        $display("FAIL drain DEPTH=%0d got=%0d pending exp=0", i + 2, exp_q[i].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ras_stack.md
RAS_STACK -- requirements
Module: ras_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of return-address entries, legal range 2..64.
REQ-002 SHALL have parameter VLEN, default 32, width of each stored address.
REQ-003 SHALL have port clk_i, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port flush_i, input, 1, clear whole stack.
REQ-006 SHALL have port push_i, input, 1, push data_i (call).
REQ-007 SHALL have port pop_i, input, 1, pop top (return).
REQ-008 SHALL have port data_i, input, VLEN, address to push.
REQ-009 SHALL have port data_o, output, VLEN, current top address.
REQ-010 SHALL have port valid_o, output, 1, top entry valid.
REQ-011 SHALL have port count_o, output, $clog2(DEPTH+1), number of valid entries.
REQ-012 SHALL have port overflow_o, output, 1, one-cycle pulse: a push overwrote the oldest entry.
REQ-013 SHALL have port underflow_o, output, 1, one-cycle pulse: a pop hit an empty stack.
REQ-014 SHALL, only with RAS_CKPT_EN, have ports ckpt_save_i (input, 1) and ckpt_restore_i (input, 1).

Function
REQ-015 SHALL store DEPTH entries {addr, valid} in a circular buffer, indexed by top pointer ptr, width $clog2(DEPTH).
REQ-016 SHALL drive data_o and valid_o combinationally from entry[ptr]; all state updates are visible the cycle after the request.
REQ-017 SHALL, on push only: ptr <= (ptr+1) mod DEPTH, entry[new ptr] <= {data_i,1}, count <= min(count+1, DEPTH).
REQ-018 SHALL, on push with count==DEPTH: overwrite the oldest entry, keep count at DEPTH, and assert overflow_o for exactly the following cycle.
REQ-019 SHALL, on pop only with count>0: clear entry[ptr].valid, set ptr <= (ptr-1) mod DEPTH, count <= count-1.
REQ-020 SHALL, on pop with count==0: leave state unchanged and assert underflow_o for the following cycle.
REQ-021 SHALL, on simultaneous push and pop with count>0: replace entry[ptr] with data_i and leave ptr and count unchanged; with count==0 the request acts as a push only.
REQ-022 SHALL apply priority flush_i > ckpt_restore_i > push/pop.
REQ-023 SHALL, on flush_i: clear all valid bits, set ptr=0 and count=0, drop any same-cycle push/pop, and produce no overflow/underflow pulse.
REQ-024 SHALL handle ptr wrap-around with no bubble, including DEPTH values that are not powers of two.

Reset
REQ-025 SHALL, at a rising clk_i edge with rst_ni=0: clear all valid bits, ptr=0, count=0, overflow_o=0, underflow_o=0, and the checkpoint registers to 0.
REQ-026 SHALL leave addr storage unreset; data_o is don't-care while valid_o=0.
REQ-027 SHALL let reset asserted mid-operation override every other input in that cycle.

Configuration
REQ-028 SHALL honour macro RAS_CKPT_EN.
REQ-029 SHALL, with RAS_CKPT_EN defined: ckpt_save_i captures {ptr,count} into checkpoint registers; ckpt_restore_i reloads ptr/count from them next cycle, ignores same-cycle push/pop/save, and does not restore entry contents overwritten since the save.
REQ-030 SHALL, without RAS_CKPT_EN: the checkpoint ports and registers are absent, and behaviour is exactly REQ-015..REQ-027.

Verification
REQ-031 SHALL cover: reset, then push 0x100, 0x200 (DEPTH=2) -> data_o=0x200, count_o=2, valid_o=1; pop -> data_o=0x100, count_o=1.
REQ-032 SHALL cover: DEPTH=2 full with 0x100, 0x200, push 0x300 -> overflow_o=1 for one cycle, count_o=2; pop twice -> 0x300 then 0x200; third pop -> underflow_o=1, count_o=0.
REQ-033 SHALL cover: count=1 top 0x400, push+pop with data_i 0x500 -> data_o=0x500, count_o=1; on empty stack push+pop 0x600 -> count_o=1, data_o=0x600.
REQ-034 SHALL cover: DEPTH=3, seven pushes 1..7 -> ptr wraps, top 7, count_o=3, overflow_o pulses 4 times; flush_i with push_i asserted -> count_o=0, valid_o=0, no pulse.
REQ-035 SHALL cover, with RAS_CKPT_EN: push 0xA0, save, push 0xB0, pop, pop, restore -> count_o=1, data_o=0xA0; with restore+push in the same cycle the push is dropped.
REQ-036 SHALL cover: rst_ni low for one cycle while push_i high at count=2 -> count_o=0, valid_o=0, overflow_o=0 next cycle.
